// File: rtl/sw_axil_pkg.sv
// Shared types and constants for the switch-to-AXI4-Lite LED master.
// Holds the FSM state enum, the AXI response code and the bus widths.
package sw_axil_pkg;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;
  localparam int AXI_STRB_W = AXI_DATA_W / 8;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_WRESP = 3'd2,
    ST_READ  = 3'd3,
    ST_RDATA = 3'd4
  } state_e;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp != RESP_OKAY);
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// Single-channel switch conditioner: two-flop synchroniser followed by a
// debounce counter that accepts a new level only after it has been stable.
module sw_debounce #(
  parameter int DEBOUNCE_CYCLES = 1250000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sw_i,
  output logic deb_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             deb_q;
  logic             deb_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // The counter only runs while the synchronised level disagrees with the
  // accepted level; any agreement (a bounce back) restarts it from zero.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (cnt_q == CNT_MAX) begin
        deb_d = sync2_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sw_i;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign deb_o = deb_q;

endmodule

// File: rtl/sw_axil_master.sv
// Debounces N_CH switches, writes their state to an AXI4-Lite LED register
// whenever it changes, then reads the register back to drive the LEDs.
module sw_axil_master
  import sw_axil_pkg::*;
#(
  parameter int                    N_CH            = 1,
  parameter int                    DEBOUNCE_CYCLES = 1250000,
  parameter logic [AXI_ADDR_W-1:0] REG_ADDR        = 32'h0000_0000
) (
  input  logic                  sysclk,
  input  logic                  rst,
  input  logic [N_CH-1:0]       sw,
  output logic [N_CH-1:0]       led,
  output logic                  err,
  output logic [AXI_ADDR_W-1:0] m_axil_awaddr,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,
  output logic [AXI_DATA_W-1:0] m_axil_wdata,
  output logic [AXI_STRB_W-1:0] m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,
  input  logic [1:0]            m_axil_bresp,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready,
  output logic [AXI_ADDR_W-1:0] m_axil_araddr,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  input  logic [AXI_DATA_W-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready
);

  state_e          state_q;
  state_e          state_d;
  logic            aw_done_q;
  logic            aw_done_d;
  logic            w_done_q;
  logic            w_done_d;
  logic [N_CH-1:0] wdata_q;
  logic [N_CH-1:0] wdata_d;
  logic [N_CH-1:0] last_sent_q;
  logic [N_CH-1:0] last_sent_d;
  logic [N_CH-1:0] led_q;
  logic [N_CH-1:0] led_d;
  logic            err_q;
  logic            err_d;

  logic [N_CH-1:0] deb_s;
  logic            awvalid_s;
  logic            wvalid_s;
  logic            bready_s;
  logic            arvalid_s;
  logic            rready_s;
  logic            rdata_unused;

  for (genvar g = 0; g < N_CH; g = g + 1) begin : g_ch
    sw_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk_i (sysclk),
      .rst_i (rst),
      .sw_i  (sw[g]),
      .deb_o (deb_s[g])
    );
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      wdata_q     <= '0;
      last_sent_q <= '0;
      led_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      wdata_q     <= wdata_d;
      last_sent_q <= last_sent_d;
      led_q       <= led_d;
      err_q       <= err_d;
    end
  end

  // Next state plus the datapath registers; wdata is frozen once latched so
  // switch activity mid-transaction is only seen on the next IDLE compare.
  always_comb begin
    state_d     = state_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    wdata_d     = wdata_q;
    last_sent_d = last_sent_q;
    led_d       = led_q;
    err_d       = err_q;
    case (state_q)
      ST_IDLE: begin
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        if (deb_s != last_sent_q) begin
          wdata_d = deb_s;
          state_d = ST_WRITE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WRITE: begin
        aw_done_d = aw_done_q | (awvalid_s & m_axil_awready);
        w_done_d  = w_done_q | (wvalid_s & m_axil_wready);
        if (aw_done_d && w_done_d) begin
          state_d = ST_WRESP;
        end else begin
          state_d = ST_WRITE;
        end
      end
      ST_WRESP: begin
        if (m_axil_bvalid) begin
          last_sent_d = wdata_q;
          err_d       = err_q | resp_is_err(m_axil_bresp);
          state_d     = ST_READ;
        end else begin
          state_d = ST_WRESP;
        end
      end
      ST_READ: begin
        if (m_axil_arready) begin
          state_d = ST_RDATA;
        end else begin
          state_d = ST_READ;
        end
      end
      ST_RDATA: begin
        if (m_axil_rvalid) begin
          if (resp_is_err(m_axil_rresp)) begin
            err_d = 1'b1;
          end else begin
            led_d = m_axil_rdata[N_CH-1:0];
          end
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RDATA;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Handshake outputs depend only on registered state, never on ready.
  always_comb begin
    awvalid_s = 1'b0;
    wvalid_s  = 1'b0;
    bready_s  = 1'b0;
    arvalid_s = 1'b0;
    rready_s  = 1'b0;
    case (state_q)
      ST_WRITE: begin
        awvalid_s = ~aw_done_q;
        wvalid_s  = ~w_done_q;
      end
      ST_WRESP: begin
        bready_s = 1'b1;
      end
      ST_READ: begin
        arvalid_s = 1'b1;
      end
      ST_RDATA: begin
        rready_s = 1'b1;
      end
      default: begin
        awvalid_s = 1'b0;
      end
    endcase
  end

  // Reset kills an in-flight handshake immediately, not one edge later.
  assign m_axil_awvalid = awvalid_s & ~rst;
  assign m_axil_wvalid  = wvalid_s & ~rst;
  assign m_axil_bready  = bready_s & ~rst;
  assign m_axil_arvalid = arvalid_s & ~rst;
  assign m_axil_rready  = rready_s & ~rst;

  assign m_axil_awaddr = REG_ADDR;
  assign m_axil_araddr = REG_ADDR;
  assign m_axil_wdata  = {{(AXI_DATA_W - N_CH){1'b0}}, wdata_q};
  assign m_axil_wstrb  = {AXI_STRB_W{1'b1}};

  assign led = led_q;
  assign err = err_q;

  assign rdata_unused = ^m_axil_rdata[AXI_DATA_W-1:N_CH];

endmodule

// File: doc/sw_axil_master.md
SW_AXIL_MASTER -- requirements
Module: sw_axil_master

Interface
REQ-001 SHALL have parameter N_CH, default 1, number of switch/LED channels (1..8).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1250000, stable cycles needed to accept a switch level (10 ms at 125 MHz).
REQ-003 SHALL have parameter REG_ADDR, default 32'h0000_0000, AXI4-Lite address of the target LED register.
REQ-004 SHALL have port sysclk  in  1  the single clock, 125 MHz; all logic on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-006 SHALL have port sw  in  N_CH  raw asynchronous switch inputs.
REQ-007 SHALL have port led  out  N_CH  LED state, read back from the slave.
REQ-008 SHALL have port err  out  1  sticky flag, set by any non-OKAY response.
REQ-009 SHALL have ports m_axil_awaddr/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready, araddr/arvalid/arready, rdata/rresp/rvalid/rready: standard AXI4-Lite master, 32-bit address and data.

Function
REQ-010 SHALL pass each sw bit through a 2-flop synchroniser before any other use.
REQ-011 SHALL update a channel's debounced bit only after its synchronised level differs from the debounced bit for DEBOUNCE_CYCLES consecutive cycles; any bounce SHALL restart that channel's counter at 0.
REQ-012 SHALL hold last_sent, the value of the last completed write; FSM states IDLE, WRITE, WRESP, READ, RDATA.
REQ-013 IDLE: when debounced != last_sent, SHALL latch debounced into wdata[N_CH-1:0] with upper bits zero and wstrb 4'hF, drive awaddr = araddr = REG_ADDR, and enter WRITE next cycle.
REQ-014 WRITE: SHALL assert awvalid and wvalid together; each SHALL drop the cycle after its own handshake (valid & ready), in either order or simultaneously; SHALL go to WRESP once both handshakes are done.
REQ-015 WRESP: SHALL hold bready=1; on bvalid, SHALL set last_sent to the latched data, set err if bresp != 2'b00, and go to READ.
REQ-016 READ: SHALL assert arvalid until arready, then go to RDATA.
REQ-017 RDATA: SHALL hold rready=1; on rvalid with rresp == 2'b00, SHALL load led from rdata[N_CH-1:0]; with a non-OKAY rresp, SHALL leave led unchanged and set err; in both cases SHALL go to IDLE.
REQ-018 Valid signals SHALL NOT depend combinationally on ready, and SHALL stay stable until their handshake completes.
REQ-019 A debounced change during a transaction SHALL NOT alter the in-flight wdata; it SHALL be picked up in IDLE by the compare in REQ-013, so only the final value is guaranteed to be written.
REQ-020 A slave that never responds SHALL stall the FSM indefinitely; no timeout.
REQ-021 err SHALL clear only on reset.

Reset
REQ-022 While rst is high, SHALL force: FSM to IDLE; all valid signals and bready/rready to 0; led, err and last_sent to 0; debounced bits and counters to 0; synchronisers to 0.
REQ-023 Reset asserted mid-transaction SHALL abandon the transaction at once, with no completion of the handshake.
REQ-024 If sw is nonzero after reset release, SHALL perform one write/read cycle once debounce completes.

Structure
REQ-025 Package sw_axil_pkg SHALL hold the FSM state enum, RESP_OKAY = 2'b00, and the AXI width constants (32/32).
REQ-026 Sub-module sw_debounce (single channel: synchroniser, counter, debounced output) SHALL be instantiated N_CH times with a generate loop.

Verification (bench: N_CH=4, DEBOUNCE_CYCLES=4, AXI4-Lite slave model with an LED register)
REQ-027 rst for 5 cycles, sw=4'b0000 -> no AXI activity; led=0; err=0.
REQ-028 sw 0->4'b1010 held -> awvalid rises 2+4+1 cycles later with wdata=32'h0000_000A; after the read, led=4'b1010.
REQ-029 sw[0] toggles every 2 cycles for 20 cycles, then sits at 0 -> no transaction; led unchanged.
REQ-030 Slave holds awready low 3 cycles after wready -> wvalid drops after 1 cycle; awvalid stays high until its handshake; exactly one write.
REQ-031 sw changes 4'b0001->4'b0011 during WRESP -> two writes, 32'h1 then 32'h3; final led=4'b0011.
REQ-032 Slave returns bresp=2'b10, then rresp=2'b10 -> err=1 and stays 1; led holds its prior value; rst -> err=0.
